gap_scan: RTL and testbench
===========================

Name: gap_scan

Overview:
- Parametrised successor to the fixed 32-bit gap counter.
- Scans a DATA_W-bit word serially, LANES bits per clock, starting at the LSB.
- Reports three results: length of the longest run of the selected bit value (0s or 1s), its start index, and the number of such runs.
- Feeds downstream bit-pattern analysis logic through a start/busy/done handshake.

Parameters:
- DATA_W, 32, width of the scanned word; must be a multiple of LANES.
- LANES, 2, bits consumed per scan cycle; 1 <= LANES <= DATA_W.
- CNT_W, $clog2(DATA_W+1), width of the length, position and count outputs.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only when not busy.
- data  in  DATA_W  word to scan; latched on an accepted start.
- mode  in  1  0 = measure runs of 0s (gaps), 1 = measure runs of 1s; latched on an accepted start.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when results become valid.
- gap  out  CNT_W  longest run length.
- gap_pos  out  CNT_W  LSB index of the longest run.
- run_cnt  out  CNT_W  number of maximal runs of the selected value.

Behaviour:
- Reset: when rst is high at a clock edge, state=IDLE and busy, done, gap, gap_pos, run_cnt are all 0. This takes priority over all other activity, including mid-scan: the scan is aborted, no done pulse is issued and partial results are discarded.
- States:
  - IDLE: waits for start.
  - SCAN: runs for DATA_W/LANES cycles.
  - DONE: lasts 1 cycle, done=1.
  - Transitions: DONE -> IDLE, or DONE -> SCAN if start is high in that cycle.
- Start acceptance: start is accepted in IDLE or DONE only. start during SCAN is ignored, with no queuing.
- Accepted start: latches data and mode, clears the internal accumulators (cur_len, best_len, best_pos, count, bit index) and enters SCAN on the next cycle.
- busy=1 exactly in SCAN cycles.
- Per SCAN cycle: processes bits idx..idx+LANES-1 in ascending order. For each bit b:
  - If b==mode: cur_len++. If cur_len was 0, record cur_start=index and increment count.
  - Otherwise: cur_len=0.
  - best_len/best_pos update when cur_len > best_len (strictly greater, so ties keep the lowest-index run).
- Runs that cross a LANES boundary continue seamlessly; cur_len carries across cycles.
- Latency: with an accepted start at edge 0, done=1 in cycle DATA_W/LANES+1. Defaults give 17.
- Outputs gap/gap_pos/run_cnt update in the same cycle that done rises and hold until the next done or reset. They do not change during a subsequent scan.
- No run of the selected value: gap=0, gap_pos=0, run_cnt=0.
- Whole word is the selected value: gap=DATA_W, gap_pos=0, run_cnt=1. CNT_W must hold DATA_W, hence the +1 in its definition.
- Arithmetic is unsigned. No counter can overflow given CNT_W.

Decomposition:
- Package gap_pkg contains:
  - state enum {IDLE, SCAN, DONE};
  - the cnt_w(DATA_W) width function;
  - the accumulator struct {cur_len, cur_start, best_len, best_pos, count}.
- One sub-module, gap_lane_step:
  - combinational;
  - inputs: accumulator struct, LANES data bits, base index, mode;
  - output: next accumulator struct.
  - Top level is the FSM, data/mode latches, index counter and result registers.

Test Plan:
- All ones, mode=0: data=32'hFFFF_FFFF, start -> done in cycle 17, gap=0, gap_pos=0, run_cnt=0. Same data with mode=1 -> gap=32, gap_pos=0, run_cnt=1.
- Sparse zeros, mode=0: data=32'hFFFF_7FBF (0s at bits 6 and 15) -> gap=1, gap_pos=6 (tie keeps lowest index), run_cnt=2.
- Mixed word, mode=0: data=32'h59EB_FB8E -> gap=3, gap_pos=4, run_cnt=8. Same word, mode=1 -> gap=7, gap_pos=11, run_cnt=7. The 1-run spans bits 11..17, crossing LANES boundaries.
- Handshake:
  - Pulse start again at scan cycle 5 -> ignored; results match the first word.
  - start held high in the DONE cycle -> new scan begins next cycle, busy rises without an IDLE gap, second done 17 cycles later.
- Reset mid-scan: rst=1 during scan cycle 8 -> next cycle busy=0 and gap/gap_pos/run_cnt=0. No done pulse for 20 cycles. A fresh start then gives correct results.
- Parameter sweep:
  - LANES=1: latency 33.
  - LANES=4: latency 9.
  - LANES=32: latency 2.
  - DATA_W=8, LANES=2, data=8'b0000_0000, mode=0 -> gap=8, gap_pos=0, run_cnt=1.
  - Every configuration is checked against a bench reference model.

Source files
------------

// File: rtl/gap_pkg.sv
// Shared types for the gap scanner: FSM states, accumulator record and output width helper.
package gap_pkg;

    // Accumulator fields are sized for any DATA_W up to 65535; modules truncate to CNT_W.
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] cur_len;
        logic [ACC_W-1:0] cur_start;
        logic [ACC_W-1:0] best_len;
        logic [ACC_W-1:0] best_pos;
        logic [ACC_W-1:0] count;
    } acc_t;

    function automatic int unsigned cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/gap_lane_step.sv
// Combinational run tracker: folds LANES bits (LSB first) into the accumulator.
module gap_lane_step
    import gap_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  acc_t             acc,
    input  logic [LANES-1:0] bits,
    input  logic [ACC_W-1:0] base,
    input  logic             mode,
    output acc_t             acc_nx
);

    always_comb begin
        acc_nx = acc;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bits[i] == mode) begin
                if (acc_nx.cur_len == '0) begin
                    acc_nx.cur_start = base + ACC_W'(i);
                    acc_nx.count     = acc_nx.count + ACC_W'(1);
                end
                acc_nx.cur_len = acc_nx.cur_len + ACC_W'(1);
                // Strictly greater, so an equal later run never displaces an earlier one.
                if (acc_nx.cur_len > acc_nx.best_len) begin
                    acc_nx.best_len = acc_nx.cur_len;
                    acc_nx.best_pos = acc_nx.cur_start;
                end
            end else begin
                acc_nx.cur_len = '0;
            end
        end
    end

endmodule

// File: rtl/gap_scan.sv
// Serial longest-run scanner: LANES bits per cycle, start/busy/done handshake.
module gap_scan
    import gap_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned CNT_W  = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  gap,
    output logic [CNT_W-1:0]  gap_pos,
    output logic [CNT_W-1:0]  run_cnt
);

    localparam logic [ACC_W-1:0] LAST_BASE = ACC_W'(DATA_W - LANES);
    localparam logic [ACC_W-1:0] BASE_INC  = ACC_W'(LANES);

    state_t            state;
    state_t            state_nx;
    logic              accept_c;
    logic              last_c;
    acc_t              acc;
    acc_t              acc_step;
    logic [DATA_W-1:0] shreg;
    logic              mode_q;
    logic [ACC_W-1:0]  base;

    gap_lane_step #(
        .LANES (LANES)
    ) u_step (
        .acc    (acc),
        .bits   (shreg[LANES-1:0]),
        .base   (base),
        .mode   (mode_q),
        .acc_nx (acc_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and start acceptance
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        last_c   = (base == LAST_BASE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (last_c) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_nx = SCAN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: word shifter, index counter, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            gap     <= '0;
            gap_pos <= '0;
            run_cnt <= '0;
            acc     <= '0;
            shreg   <= '0;
            mode_q  <= 1'b0;
            base    <= '0;
        end else begin
            busy <= (state_nx == SCAN);
            done <= (state_nx == DONE);
            if (accept_c) begin
                shreg  <= data;
                mode_q <= mode;
                acc    <= '0;
                base   <= '0;
            end else if (state == SCAN) begin
                acc   <= acc_step;
                shreg <= shreg >> LANES;
                base  <= base + BASE_INC;
                // Results publish together with done and hold through the next scan.
                if (last_c) begin
                    gap     <= CNT_W'(acc_step.best_len);
                    gap_pos <= CNT_W'(acc_step.best_pos);
                    run_cnt <= CNT_W'(acc_step.count);
                end
            end
        end
    end

endmodule

// File: tb/tb_gap_scan.sv
// Self-checking bench for gap_scan: vector table, handshake corners, random words, parameter sweep.
module tb_gap_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [5:0]  gap;
    logic [5:0]  gap_pos;
    logic [5:0]  run_cnt;

    logic        sw_start;
    logic        sw_mode;
    logic [31:0] sw_data;
    logic [3:0]  sw_busy;
    logic [3:0]  sw_done;
    logic [5:0]  sw_gap [4];
    logic [5:0]  sw_pos [4];
    logic [5:0]  sw_cnt [4];
    logic [3:0]  g8, p8, c8;

    int checks = 0;
    int errors = 0;

    gap_scan u0 (.clk(clk), .rst(rst), .start(start), .data(data), .mode(mode),
                 .busy(busy), .done(done), .gap(gap), .gap_pos(gap_pos), .run_cnt(run_cnt));

    gap_scan #(.DATA_W(32), .LANES(1)) u1 (.clk(clk), .rst(rst), .start(sw_start), .data(sw_data),
        .mode(sw_mode), .busy(sw_busy[0]), .done(sw_done[0]), .gap(sw_gap[0]), .gap_pos(sw_pos[0]),
        .run_cnt(sw_cnt[0]));
    gap_scan #(.DATA_W(32), .LANES(4)) u2 (.clk(clk), .rst(rst), .start(sw_start), .data(sw_data),
        .mode(sw_mode), .busy(sw_busy[1]), .done(sw_done[1]), .gap(sw_gap[1]), .gap_pos(sw_pos[1]),
        .run_cnt(sw_cnt[1]));
    gap_scan #(.DATA_W(32), .LANES(32)) u3 (.clk(clk), .rst(rst), .start(sw_start), .data(sw_data),
        .mode(sw_mode), .busy(sw_busy[2]), .done(sw_done[2]), .gap(sw_gap[2]), .gap_pos(sw_pos[2]),
        .run_cnt(sw_cnt[2]));
    gap_scan #(.DATA_W(8), .LANES(2)) u4 (.clk(clk), .rst(rst), .start(sw_start), .data(sw_data[7:0]),
        .mode(sw_mode), .busy(sw_busy[3]), .done(sw_done[3]), .gap(g8), .gap_pos(p8), .run_cnt(c8));

    assign sw_gap[3] = {2'b00, g8};
    assign sw_pos[3] = {2'b00, p8};
    assign sw_cnt[3] = {2'b00, c8};

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          g;
        int          p;
        int          c;
    } vec_t;

    // Enumerate maximal runs directly and keep the first longest one.
    function automatic void model(input logic [31:0] d, input int w, input logic m,
                                  output int g, output int p, output int c);
        int l;
        g = 0; p = 0; c = 0;
        for (int s = 0; s < w; s++) begin
            if (d[s] == m) begin
                if (s == 0 || d[s-1] != m) begin
                    l = 0;
                    while (s + l < w && d[s+l] == m) l++;
                    c++;
                    if (l > g) begin
                        g = l;
                        p = s;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a scan on u0 and return the done cycle (accept edge counts as cycle 1), -1 on timeout.
    task automatic run0(input logic [31:0] d, input logic m, output int lat);
        int bb;
        bb = 0;
        data = d; mode = m; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        if (!busy) bb++;
        for (int t = 1; t <= 60; t++) begin
            step();
            if (done) begin
                lat = t + 1;
                break;
            end
            if (!busy) bb++;
        end
        chk("busy held during scan", bb, 0);
    endtask

    task automatic run_sw(input logic [31:0] d, input logic m, output int g4, output int p4, output int c4);
        int lat [4];
        int g [4];
        int p [4];
        int c [4];
        int wid [4];
        int ln [4];
        int eg, ep, ec;
        wid = '{32, 32, 32, 8};
        ln  = '{1, 4, 32, 2};
        sw_data = d; sw_mode = m; sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1; g[k] = 0; p[k] = 0; c[k] = 0;
            chk($sformatf("sweep%0d busy after start", k), int'(sw_busy[k]), 1);
        end
        for (int t = 1; t <= 40; t++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (sw_done[k] && lat[k] < 0) begin
                    lat[k] = t + 1;
                    g[k] = int'(sw_gap[k]); p[k] = int'(sw_pos[k]); c[k] = int'(sw_cnt[k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            model(d, wid[k], m, eg, ep, ec);
            chk($sformatf("sweep%0d latency", k), lat[k], wid[k] / ln[k] + 1);
            chk($sformatf("sweep%0d gap", k), g[k], eg);
            chk($sformatf("sweep%0d gap_pos", k), p[k], ep);
            chk($sformatf("sweep%0d run_cnt", k), c[k], ec);
        end
        g4 = g[3]; p4 = p[3]; c4 = c[3];
    endtask

    initial begin
        vec_t vecs [5];
        int   lat, eg, ep, ec, prev, nd, g4, p4, c4;
        logic [31:0] rd;
        logic        rm;

        vecs[0] = '{32'hFFFF_FFFF, 1'b0, 0, 0, 0};
        vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32, 0, 1};
        vecs[2] = '{32'hFFFF_7FBF, 1'b0, 1, 6, 2};
        vecs[3] = '{32'h59EB_FB8E, 1'b0, 3, 4, 8};
        vecs[4] = '{32'h59EB_FB8E, 1'b1, 7, 11, 7};

        rst = 1'b1; start = 1'b0; data = '0; mode = 1'b0;
        sw_start = 1'b0; sw_data = '0; sw_mode = 1'b0;
        step(); step();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset gap", int'(gap), 0);
        chk("reset gap_pos", int'(gap_pos), 0);
        chk("reset run_cnt", int'(run_cnt), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].d, vecs[i].m, lat);
            chk($sformatf("vec%0d latency", i), lat, 17);
            chk($sformatf("vec%0d gap", i), int'(gap), vecs[i].g);
            chk($sformatf("vec%0d gap_pos", i), int'(gap_pos), vecs[i].p);
            chk($sformatf("vec%0d run_cnt", i), int'(run_cnt), vecs[i].c);
            step();
            chk($sformatf("vec%0d done one cycle", i), int'(done), 0);
        end

        for (int i = 0; i < 20; i++) begin
            rd = $urandom;
            if (i % 3 == 1) rd = rd & $urandom;
            if (i % 3 == 2) rd = rd | $urandom;
            rm = 1'($urandom_range(0, 1));
            run0(rd, rm, lat);
            model(rd, 32, rm, eg, ep, ec);
            chk($sformatf("rand%0d latency", i), lat, 17);
            chk($sformatf("rand%0d gap", i), int'(gap), eg);
            chk($sformatf("rand%0d gap_pos", i), int'(gap_pos), ep);
            chk($sformatf("rand%0d run_cnt", i), int'(run_cnt), ec);
        end

        // start pulsed during scan cycle 5 must be ignored and not queued
        run0(32'h0000_00F0, 1'b1, lat);
        prev = int'(gap);
        data = 32'h59EB_FB8E; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) step();
        data = 32'h0000_0000; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("results hold during scan", int'(gap), prev);
        lat = -1;
        for (int t = 6; t <= 60; t++) begin
            step();
            if (done) begin
                lat = t + 1;
                break;
            end
        end
        chk("ignored start latency", lat, 17);
        chk("ignored start gap", int'(gap), 7);
        chk("ignored start gap_pos", int'(gap_pos), 11);
        chk("ignored start run_cnt", int'(run_cnt), 7);
        step();
        chk("no queued scan", int'(busy), 0);

        // start held in the DONE cycle chains straight into the next scan
        run0(32'hFFFF_7FBF, 1'b0, lat);
        chk("chain first latency", lat, 17);
        data = 32'h59EB_FB8E; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("chain busy without idle", int'(busy), 1);
        chk("chain done dropped", int'(done), 0);
        chk("chain old gap held", int'(gap), 1);
        lat = -1;
        for (int t = 1; t <= 60; t++) begin
            step();
            if (done) begin
                lat = t + 1;
                break;
            end
        end
        chk("chain second done distance", lat, 17);
        chk("chain gap", int'(gap), 3);
        chk("chain gap_pos", int'(gap_pos), 4);
        chk("chain run_cnt", int'(run_cnt), 8);
        step();

        // reset during scan cycle 8 aborts the scan and clears results
        data = 32'hFFFF_FFFF; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 7; t++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort gap", int'(gap), 0);
        chk("abort gap_pos", int'(gap_pos), 0);
        chk("abort run_cnt", int'(run_cnt), 0);
        nd = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (done || busy) nd++;
        end
        chk("no activity after abort", nd, 0);
        run0(32'h59EB_FB8E, 1'b1, lat);
        chk("post-abort latency", lat, 17);
        chk("post-abort gap", int'(gap), 7);
        chk("post-abort gap_pos", int'(gap_pos), 11);
        chk("post-abort run_cnt", int'(run_cnt), 7);

        // parameter sweep
        run_sw(32'h0000_0000, 1'b0, g4, p4, c4);
        chk("w8 all zero gap", g4, 8);
        chk("w8 all zero gap_pos", p4, 0);
        chk("w8 all zero run_cnt", c4, 1);
        run_sw(32'hFFFF_FFFF, 1'b1, g4, p4, c4);
        run_sw(32'h59EB_FB8E, 1'b0, g4, p4, c4);
        run_sw(32'h59EB_FB8E, 1'b1, g4, p4, c4);
        for (int i = 0; i < 8; i++) begin
            rd = $urandom;
            rm = 1'($urandom_range(0, 1));
            run_sw(rd, rm, g4, p4, c4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
